// File: rtl/alu_mc.sv
// alu_mc: multicycle ALU.
// Single-cycle ops (logic, add/sub, shifts, compares) register their result on the accepting
// edge. MULTU (shift-add) and DIVU (restoring) iterate one bit per cycle for WIDTH cycles.
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   start, op          request and 4-bit operation code; start is ignored while busy
//   a, b, shamt        operands and shift amount, latched at acceptance
//   out, hi, zout      result / high product or remainder / out==0, held between dones
//   busy, done         iteration in progress / one-cycle result-valid pulse
module alu_mc #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   hi,
  output logic               zout,
  output logic               busy,
  output logic               done
);

  localparam logic [3:0] OpAnd   = 4'd0;
  localparam logic [3:0] OpOr    = 4'd1;
  localparam logic [3:0] OpNor   = 4'd2;
  localparam logic [3:0] OpAdd   = 4'd3;
  localparam logic [3:0] OpSub   = 4'd4;
  localparam logic [3:0] OpSll   = 4'd5;
  localparam logic [3:0] OpSrl   = 4'd6;
  localparam logic [3:0] OpSra   = 4'd7;
  localparam logic [3:0] OpSlt   = 4'd8;
  localparam logic [3:0] OpSltu  = 4'd9;
  localparam logic [3:0] OpMultu = 4'd10;
  localparam logic [3:0] OpDivu  = 4'd11;

  localparam logic [SHAMT_W-1:0] LastCnt = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StIter, StFin} state_e;

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand (MULTU) or divisor (DIVU)
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {hi, lo}: product, or {remainder, dividend/quotient}
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zout_q, zout_d;
  logic               done_q, done_d;

  // Single-cycle datapath
  logic [WIDTH:0]   sub_full;
  logic             slt_ovf;
  logic [WIDTH-1:0] alu_out, alu_hi;
  logic             iter_start;

  assign sub_full   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  // Signed overflow of a-b: operand signs differ and result sign differs from a
  assign slt_ovf    = (a[WIDTH-1] ^ b[WIDTH-1]) & (sub_full[WIDTH-1] ^ a[WIDTH-1]);
  assign iter_start = ((op == OpMultu) || (op == OpDivu)) && (b != '0);

  always_comb begin
    alu_out = '0;
    alu_hi  = '0;
    case (op)
      OpAnd:  alu_out = a & b;
      OpOr:   alu_out = a | b;
      OpNor:  alu_out = ~(a | b);
      OpAdd:  alu_out = a + b;
      OpSub:  alu_out = sub_full[WIDTH-1:0];
      OpSll:  alu_out = a << shamt;
      OpSrl:  alu_out = a >> shamt;
      OpSra:  alu_out = $unsigned($signed(a) >>> shamt);
      OpSlt:  alu_out = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ slt_ovf};
      OpSltu: alu_out = {{(WIDTH-1){1'b0}}, ~sub_full[WIDTH]};
      // Only reached with b==0; nonzero divisors iterate
      OpDivu: begin
        alu_out = '1;
        alu_hi  = a;
      end
      // MULTU by zero and codes 12-15 give zero
      default: ;
    endcase
  end

  // One iteration step
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_diff;
  logic [2*WIDTH-1:0] acc_step;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};

  always_comb begin
    acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_step = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    out_d    = out_q;
    hi_d     = hi_q;
    zout_d   = zout_q;
    done_d   = 1'b0;
    case (state_q)
      StIter: begin
        acc_d = acc_step;
        cnt_d = cnt_q + SHAMT_W'(1);
        if (cnt_q == LastCnt) begin
          state_d = StFin;
          out_d   = acc_step[WIDTH-1:0];
          hi_d    = acc_step[2*WIDTH-1:WIDTH];
          zout_d  = (acc_step[WIDTH-1:0] == '0);
          done_d  = 1'b1;
        end
      end
      // FIN behaves as IDLE so a start in the done cycle is accepted
      default: begin
        state_d = StIdle;
        if (start) begin
          if (iter_start) begin
            state_d  = StIter;
            cnt_d    = '0;
            is_div_d = (op == OpDivu);
            opnd_d   = (op == OpDivu) ? b : a;
            acc_d    = {{WIDTH{1'b0}}, (op == OpDivu) ? a : b};
          end else begin
            out_d  = alu_out;
            hi_d   = alu_hi;
            zout_d = (alu_out == '0);
            done_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      hi_q     <= '0;
      zout_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      hi_q     <= hi_d;
      zout_q   <= zout_d;
      done_q   <= done_d;
    end
  end

  assign out  = out_q;
  assign hi   = hi_q;
  assign zout = zout_q;
  assign done = done_q;
  assign busy = (state_q == StIter);

endmodule
